// File: rtl/hazard_ctrl.sv
// Hazard and multi-cycle scheduler for the 5-stage MIPS core: load-use stalls,
// taken-branch flushes, and sequencing of the multiply/divide unit.
module hazard_ctrl #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [4:0] Ra_D,
  input  logic [4:0] Rb_D,
  input  logic       uses_Ra_D,
  input  logic       uses_Rb_D,
  input  logic [4:0] WriteReg_E,
  input  logic       RegWrite_E,
  input  logic       MemRead_E,
  input  logic       branch_taken_E,
  input  logic       mdu_start_D,
  input  logic       mdu_div_D,
  output logic       stall_F,
  output logic       stall_D,
  output logic       flush_D,
  output logic       flush_E,
  output logic       mdu_go,
  output logic       mdu_abort,
  output logic       mdu_busy,
  output logic       mdu_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  state_t           state_r;
  state_t           state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             lu_s;

  // Load-use: a load in EX targets a register the ID instruction reads.
  always_comb begin
    lu_s = MemRead_E & RegWrite_E & (WriteReg_E != 5'd0) &
           ((uses_Ra_D & (Ra_D == WriteReg_E)) | (uses_Rb_D & (Rb_D == WriteReg_E)));
  end

  // State and latency counter register.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_r <= IDLE;
      cnt_r   <= '0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Next-state and hazard outputs; a taken branch overrides everything else.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    stall_F     = 1'b0;
    stall_D     = 1'b0;
    flush_D     = 1'b0;
    flush_E     = 1'b0;
    mdu_go      = 1'b0;
    mdu_abort   = 1'b0;
    mdu_busy    = 1'b0;
    mdu_done    = 1'b0;
    case (state_r)
      IDLE: begin
        if (branch_taken_E) begin
          flush_D = 1'b1;
          flush_E = 1'b1;
        end else if (lu_s) begin
          stall_F = 1'b1;
          stall_D = 1'b1;
          flush_E = 1'b1;
        end else if (mdu_start_D) begin
          stall_F     = 1'b1;
          stall_D     = 1'b1;
          flush_E     = 1'b1;
          mdu_go      = 1'b1;
          state_nxt_s = BUSY;
          cnt_nxt_s   = mdu_div_D ? DIV_LOAD : MUL_LOAD;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BUSY: begin
        mdu_busy = 1'b1;
        if (branch_taken_E) begin
          flush_D     = 1'b1;
          flush_E     = 1'b1;
          mdu_abort   = 1'b1;
          state_nxt_s = IDLE;
          cnt_nxt_s   = '0;
        end else begin
          stall_F = 1'b1;
          stall_D = 1'b1;
          flush_E = 1'b1;
          if (cnt_r == '0) begin
            state_nxt_s = DONE;
          end else begin
            cnt_nxt_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
      end
      DONE: begin
        // The MDU instruction leaves ID at this edge, so no new start is taken.
        mdu_busy    = 1'b1;
        mdu_done    = 1'b1;
        state_nxt_s = IDLE;
        if (branch_taken_E) begin
          flush_D   = 1'b1;
          flush_E   = 1'b1;
          mdu_abort = 1'b1;
        end else begin
          flush_D = 1'b0;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = '0;
      end
    endcase
  end

endmodule
